// File: rtl/lsa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsa_pkg: constants and FSM encoding shared by the LSA core and the   |
// | memory responder.                                  Rev 1.0           |
// +----------------------------------------------------------------------+
package lsa_pkg;

  localparam logic [15:0] ADDR_LED    = 16'hFF00;
  localparam logic [15:0] ADDR_TIMER  = 16'hFF01;
  localparam logic [15:0] ADDR_STATUS = 16'hFF02;
  localparam logic [15:0] ADDR_HALT   = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_COPY = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lsa_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsa_mem_responder_if: single-cycle LSA memory bus between core and   |
// | memory responder.                                  Rev 1.0           |
// +----------------------------------------------------------------------+
interface lsa_mem_responder_if;

  logic        mem_fetch;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] mem_add;
  logic [15:0] mem_out;
  logic [15:0] mem_in;

  modport master (
    output mem_fetch, mem_oe, mem_we, mem_add, mem_out,
    input  mem_in
  );

  modport slave (
    input  mem_fetch, mem_oe, mem_we, mem_add, mem_out,
    output mem_in
  );

endinterface
`default_nettype wire

// File: rtl/lsa_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsa_ram: 2^AW x 16 distributed RAM, async read, sync write.          |
// |                                                    Rev 1.0           |
// +----------------------------------------------------------------------+
module lsa_ram #(
  parameter int AW = 8
) (
  input  wire logic          clock_in,
  input  wire logic          we,
  input  wire logic [AW-1:0] wadd,
  input  wire logic [15:0]   wdata,
  input  wire logic [AW-1:0] radd,
  output logic      [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clock_in) begin
    if (we) begin
      mem[wadd] <= wdata;
    end
  end

  assign rdata = mem[radd];

endmodule
`default_nettype wire

// File: rtl/lsa_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsa_mem_responder: boot copy, RAM, LED/timer/status I/O page and     |
// | halt detect for the LSA core.                      Rev 1.0           |
// +----------------------------------------------------------------------+
module lsa_mem_responder
  import lsa_pkg::*;
#(
  parameter int          RAM_AW     = 8,
  parameter int          BOOT_WORDS = 64,
  parameter logic [15:0] PRESCALE   = 16'd50000
) (
  input  wire logic              clock_in,
  input  wire logic              reset_in,
  lsa_mem_responder_if.slave     bus,
  output logic                   core_reset_out,
  output logic [RAM_AW-1:0]      boot_add,
  input  wire logic [15:0]       boot_data,
  output logic [7:0]             led_out,
  output logic                   halt_out
);

  localparam int                CW            = RAM_AW + 1;
  localparam logic [CW-1:0]     BOOT_LAST     = CW'(BOOT_WORDS);
  localparam logic [RAM_AW-1:0] BOOT_ADD_MAX  = RAM_AW'(BOOT_WORDS - 1);
  localparam logic [16:0]       RAM_LIMIT     = 17'(1) << RAM_AW;
  localparam logic [15:0]       PRESCALE_LAST = PRESCALE - 16'd1;

  state_t            state;
  logic [CW-1:0]     copy_cnt;
  logic [15:0]       timer;
  logic [15:0]       prescaler;
  logic              tick;
  logic              halt_seen;

  logic              in_ram;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_wadd;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              wrap;
  logic              halt_qual;
  logic              unused_fetch;

  assign unused_fetch = bus.mem_fetch;
  assign in_ram       = {1'b0, bus.mem_add} < RAM_LIMIT;
  assign wrap         = (prescaler == PRESCALE_LAST);
  assign halt_qual    = (bus.mem_add == ADDR_HALT) && !bus.mem_oe && !bus.mem_we;

  // copy_cnt lags boot_add by one edge to cover the boot ROM's read latency
  always_comb begin
    ram_we    = 1'b0;
    ram_wadd  = bus.mem_add[RAM_AW-1:0];
    ram_wdata = bus.mem_out;
    if (state == ST_COPY) begin
      ram_we    = (copy_cnt != '0);
      ram_wadd  = RAM_AW'(copy_cnt - 1'b1);
      ram_wdata = boot_data;
    end else begin
      ram_we    = bus.mem_we && in_ram;
    end
  end

  lsa_ram #(.AW(RAM_AW)) u_ram (
    .clock_in (clock_in),
    .we       (ram_we),
    .wadd     (ram_wadd),
    .wdata    (ram_wdata),
    .radd     (bus.mem_add[RAM_AW-1:0]),
    .rdata    (ram_rdata)
  );

  always_comb begin
    bus.mem_in = 16'h0000;
    if (state == ST_RUN && bus.mem_oe) begin
      if (in_ram) begin
        bus.mem_in = ram_rdata;
      end else begin
        case (bus.mem_add)
          ADDR_LED:    bus.mem_in = {8'h00, led_out};
          ADDR_TIMER:  bus.mem_in = timer;
          ADDR_STATUS: bus.mem_in = {15'h0000, tick};
          default:     bus.mem_in = 16'h0000;
        endcase
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= ST_COPY;
      copy_cnt       <= '0;
      boot_add       <= '0;
      core_reset_out <= 1'b0;
      led_out        <= 8'h00;
      halt_out       <= 1'b0;
      halt_seen      <= 1'b0;
      timer          <= 16'h0000;
      prescaler      <= 16'h0000;
      tick           <= 1'b0;
    end else begin
      case (state)
        ST_COPY: begin
          if (boot_add != BOOT_ADD_MAX) begin
            boot_add <= boot_add + 1'b1;
          end
          copy_cnt <= copy_cnt + 1'b1;
          if (copy_cnt == BOOT_LAST) begin
            core_reset_out <= 1'b1;
            state          <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A timer write restarts the tick period from zero
          if (bus.mem_we && bus.mem_add == ADDR_TIMER) begin
            timer     <= bus.mem_out;
            prescaler <= 16'h0000;
          end else if (wrap) begin
            timer     <= timer + 16'd1;
            prescaler <= 16'h0000;
          end else begin
            prescaler <= prescaler + 16'd1;
          end
          if (wrap) begin
            tick <= 1'b1;
          end else if (bus.mem_oe && bus.mem_add == ADDR_STATUS) begin
            tick <= 1'b0;
          end
          if (bus.mem_we && bus.mem_add == ADDR_LED) begin
            led_out <= bus.mem_out[7:0];
          end
          halt_seen <= halt_qual;
          if (halt_qual && halt_seen) begin
            halt_out <= 1'b1;
          end
        end
        default: state <= ST_COPY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsa_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsa_mem_responder: directed scoreboard bench for the responder.   |
// |                                                    Rev 1.0           |
// +----------------------------------------------------------------------+
module tb_lsa_mem_responder;

  logic        clock_in;
  logic        reset_in;
  logic        core_reset_out;
  logic [7:0]  boot_add;
  logic [15:0] boot_data;
  logic [7:0]  led_out;
  logic        halt_out;
  logic [15:0] rom [4];

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q [$];
  string       tag_q [$];

  lsa_mem_responder_if bus ();

  lsa_mem_responder #(
    .RAM_AW     (8),
    .BOOT_WORDS (4),
    .PRESCALE   (16'd4)
  ) dut (
    .clock_in       (clock_in),
    .reset_in       (reset_in),
    .bus            (bus),
    .core_reset_out (core_reset_out),
    .boot_add       (boot_add),
    .boot_data      (boot_data),
    .led_out        (led_out),
    .halt_out       (halt_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Synchronous boot ROM: data for boot_add appears one edge later
  always @(posedge clock_in) boot_data <= rom[boot_add[1:0]];

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Combinational read inside the current cycle; oe is dropped before the next edge
  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus.mem_add = addr;
    bus.mem_oe  = 1'b1;
    push(tag, exp);
    #1;
    pop_check(bus.mem_in);
    bus.mem_oe  = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    bus.mem_add = addr;
    bus.mem_out = data;
    bus.mem_we  = 1'b1;
    tick();
    bus.mem_we  = 1'b0;
  endtask

  initial begin
    rom[0] = 16'hC001; rom[1] = 16'h8203; rom[2] = 16'h4228; rom[3] = 16'hF000;
    reset_in      = 1'b0;
    bus.mem_fetch = 1'b0;
    bus.mem_oe    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_add   = 16'h0000;
    bus.mem_out   = 16'h0000;
    repeat (2) tick();
    check("rst_core_reset", {15'h0, core_reset_out}, 16'h0000);
    check("rst_boot_add",   {8'h0, boot_add},        16'h0000);
    check("rst_led",        {8'h0, led_out},         16'h0000);
    check("rst_halt",       {15'h0, halt_out},       16'h0000);

    // Boot copy with the core trying to read during COPY
    reset_in   = 1'b1;
    bus.mem_oe = 1'b1;
    tick();
    check("boot_add_e1", {8'h0, boot_add}, 16'h0001);
    push("copy_mem_in_e1", 16'h0000);
    pop_check(bus.mem_in);
    repeat (3) tick();
    check("boot_add_hold", {8'h0, boot_add}, 16'h0003);
    check("core_reset_e4", {15'h0, core_reset_out}, 16'h0000);
    push("copy_mem_in_e4", 16'h0000);
    pop_check(bus.mem_in);
    tick();
    check("core_reset_e5", {15'h0, core_reset_out}, 16'h0001);
    bus.mem_oe = 1'b0;
    rd("ram0", 16'h0000, 16'hC001);
    rd("ram1", 16'h0001, 16'h8203);
    rd("ram2", 16'h0002, 16'h4228);
    rd("ram3", 16'h0003, 16'hF000);

    // Timer with PRESCALE=4: counting starts on RUN edge 1
    bus.mem_add = 16'h0000;
    repeat (8) tick();
    rd("timer_8", 16'hFF01, 16'h0002);
    rd("status_8", 16'hFF02, 16'h0001);
    bus.mem_add = 16'hFF02; bus.mem_oe = 1'b1;
    tick();
    bus.mem_oe = 1'b0;
    rd("status_cleared", 16'hFF02, 16'h0000);
    repeat (2) tick();
    bus.mem_add = 16'hFF02; bus.mem_oe = 1'b1;
    tick();
    bus.mem_oe = 1'b0;
    rd("tick_set_wins", 16'hFF02, 16'h0001);
    rd("timer_12", 16'hFF01, 16'h0003);
    bus.mem_add = 16'hFF02; bus.mem_oe = 1'b1;
    tick();
    bus.mem_oe = 1'b0;
    rd("status_cleared2", 16'hFF02, 16'h0000);
    wr(16'hFF01, 16'hFFFF);
    rd("timer_loaded", 16'hFF01, 16'hFFFF);
    repeat (3) tick();
    rd("timer_no_wrap_yet", 16'hFF01, 16'hFFFF);
    tick();
    rd("timer_wrap", 16'hFF01, 16'h0000);
    rd("tick_after_wrap", 16'hFF02, 16'h0001);

    // RAM access
    wr(16'h0010, 16'h1234);
    rd("ram_wr_rd", 16'h0010, 16'h1234);
    bus.mem_add = 16'h0010; bus.mem_out = 16'h5678;
    bus.mem_we  = 1'b1;     bus.mem_oe  = 1'b1;
    push("rd_during_wr", 16'h1234);
    #1;
    pop_check(bus.mem_in);
    tick();
    bus.mem_we = 1'b0; bus.mem_oe = 1'b0;
    rd("ram_after_rdwr", 16'h0010, 16'h5678);
    wr(16'h0100, 16'hBEEF);
    rd("out_of_ram", 16'h0100, 16'h0000);
    rd("no_alias", 16'h0000, 16'hC001);

    // LED and unmapped I/O
    wr(16'hFF00, 16'hABCD);
    check("led_out", {8'h0, led_out}, 16'h00CD);
    rd("led_read", 16'hFF00, 16'h00CD);
    wr(16'hFF03, 16'h5555);
    rd("unmapped", 16'hFF03, 16'h0000);
    bus.mem_add = 16'hFF00;
    push("oe_low", 16'h0000);
    #1;
    pop_check(bus.mem_in);

    // Halt detect: single-cycle pulse, then a qualifying pair
    bus.mem_add = 16'hFFFF;
    tick();
    bus.mem_add = 16'h0000;
    check("halt_pulse_e1", {15'h0, halt_out}, 16'h0000);
    tick();
    check("halt_pulse_e2", {15'h0, halt_out}, 16'h0000);
    bus.mem_add = 16'hFFFF;
    tick();
    check("halt_first_edge", {15'h0, halt_out}, 16'h0000);
    tick();
    check("halt_second_edge", {15'h0, halt_out}, 16'h0001);
    bus.mem_add = 16'h0000;
    tick();
    check("halt_sticky", {15'h0, halt_out}, 16'h0001);

    // Asynchronous reset mid-operation, then again mid-COPY with a new image
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    reset_in = 1'b0;
    #1;
    check("async_rst_core", {15'h0, core_reset_out}, 16'h0000);
    check("async_rst_led",  {8'h0, led_out},         16'h0000);
    check("async_rst_halt", {15'h0, halt_out},       16'h0000);
    reset_in = 1'b1;
    repeat (2) tick();
    check("boot_add_mid", {8'h0, boot_add}, 16'h0002);
    reset_in = 1'b0;
    #1;
    check("midcopy_boot_add", {8'h0, boot_add}, 16'h0000);
    check("midcopy_core",     {15'h0, core_reset_out}, 16'h0000);
    reset_in = 1'b1;
    repeat (4) tick();
    check("reboot_core_e4", {15'h0, core_reset_out}, 16'h0000);
    tick();
    check("reboot_core_e5", {15'h0, core_reset_out}, 16'h0001);
    rd("reboot_ram0", 16'h0000, 16'h1111);
    rd("reboot_ram1", 16'h0001, 16'h2222);
    rd("reboot_ram2", 16'h0002, 16'h3333);
    rd("reboot_ram3", 16'h0003, 16'h4444);
    tick();
    rd("reboot_timer", 16'hFF01, 16'h0000);
    rd("reboot_led",   16'hFF00, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
